gate_array_pipe: RTL and testbench

Parametrised, pipelined bitwise logic unit that generalises the single-bit NAND gate into a WIDTH-bit, eight-operation datapath with a valid/ready stream interface. It sits between a producer and a consumer in the combinational-circuit library as the registered, back-pressurable form of the basic gates. It provides full throughput, fixed 2-cycle latency, and zero/all-ones result flags.

---
 rtl/gate_array_pipe.sv | 142 ++++++++++++++
 tb/tb_gate_array_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_array_pipe.sv
// gate_array_pipe: two-stage registered WIDTH-bit logic unit (NAND/AND/OR/NOR/XOR/XNOR/NOT/PASS)
// with a valid/ready stream on both sides. Define GATE_ARRAY_PERF_EN to add the op_count port.
module gate_array_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_ones
`ifdef GATE_ARRAY_PERF_EN
    ,
    output logic [15:0]      op_count
`endif
);

    localparam logic [2:0] OP_NAND = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    function automatic logic [WIDTH-1:0] gate_eval(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [2:0]       op
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_NAND: r = ~(a & b);
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            OP_NOT:  r = ~a;
            OP_PASS: r = a;
            default: r = a;
        endcase
        return r;
    endfunction

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic [2:0]       s1_op_r;
    logic             s2_valid_r;
    logic [WIDTH-1:0] s2_y_r;
    logic             s2_zero_r;
    logic             s2_ones_r;

    logic             s2_free_s;
    logic             s1_move_s;
    logic             in_ready_s;
    logic             in_fire_s;
    logic [WIDTH-1:0] result_s;
    logic             zero_s;
    logic             ones_s;

    // Handshake decisions, stage-2 result and its flags
    always_comb begin
        s2_free_s  = ~s2_valid_r | out_ready;
        s1_move_s  = s1_valid_r & s2_free_s;
        in_ready_s = ~s1_valid_r | s2_free_s;
        in_fire_s  = in_valid & in_ready_s;
        result_s   = gate_eval(s1_a_r, s1_b_r, s1_op_r);
        zero_s     = (result_s == {WIDTH{1'b0}});
        ones_s     = (result_s == {WIDTH{1'b1}});
    end

    // Stage 1: operand capture; the slot empties when its contents move on
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_op_r    <= 3'd0;
        end else if (in_fire_s) begin
            s1_valid_r <= 1'b1;
            s1_a_r     <= in_a;
            s1_b_r     <= in_b;
            s1_op_r    <= in_op;
        end else if (s1_move_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2: result register; data holds while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_y_r     <= {WIDTH{1'b0}};
            s2_zero_r  <= 1'b0;
            s2_ones_r  <= 1'b0;
        end else if (s1_move_s) begin
            s2_valid_r <= 1'b1;
            s2_y_r     <= result_s;
            s2_zero_r  <= zero_s;
            s2_ones_r  <= ones_s;
        end else if (out_ready) begin
            s2_valid_r <= 1'b0;
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = s2_valid_r;
    assign out_y     = s2_y_r;
    assign out_zero  = s2_zero_r;
    assign out_ones  = s2_ones_r;

`ifdef GATE_ARRAY_PERF_EN
    logic [15:0] op_count_r;

    // Saturating count of accepted input transactions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_r <= 16'd0;
        end else if (in_fire_s && (op_count_r != 16'hFFFF)) begin
            op_count_r <= op_count_r + 16'd1;
        end else begin
            op_count_r <= op_count_r;
        end
    end

    assign op_count = op_count_r;
`endif

endmodule

// File: tb/tb_gate_array_pipe.sv
// Directed self-checking bench for gate_array_pipe: ops, WIDTH=1 NAND, stall/recovery,
// toggled back-pressure, async reset, and (with GATE_ARRAY_PERF_EN) op_count saturation.
module tb_gate_array_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic       out_zero;
    logic       out_ones;
`ifdef GATE_ARRAY_PERF_EN
    logic [15:0] op_count;
`endif

    logic       w1_in_valid;
    logic       w1_in_ready;
    logic [0:0] w1_in_a;
    logic [0:0] w1_in_b;
    logic [2:0] w1_in_op;
    logic       w1_out_valid;
    logic       w1_out_ready;
    logic [0:0] w1_out_y;
    logic       w1_out_zero;
    logic       w1_out_ones;
`ifdef GATE_ARRAY_PERF_EN
    logic [15:0] w1_op_count;
`endif

    gate_array_pipe #(.WIDTH(8)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_zero(out_zero), .out_ones(out_ones)
`ifdef GATE_ARRAY_PERF_EN
        , .op_count(op_count)
`endif
    );

    gate_array_pipe #(.WIDTH(1)) u_dut_w1 (
        .clk(clk), .rst(rst),
        .in_valid(w1_in_valid), .in_ready(w1_in_ready),
        .in_a(w1_in_a), .in_b(w1_in_b), .in_op(w1_in_op),
        .out_valid(w1_out_valid), .out_ready(w1_out_ready),
        .out_y(w1_out_y), .out_zero(w1_out_zero), .out_ones(w1_out_ones)
`ifdef GATE_ARRAY_PERF_EN
        , .op_count(w1_op_count)
`endif
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         accepted = 0;
    int         out_fires = 0;
    logic [7:0] cur_exp;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return ~(a & b);
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    task automatic put(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        cur_exp = model(a, b, op);
    endtask

    // Advance one clock; scoreboard both handshakes just before the edge
    task automatic step();
        logic [7:0] e;
        #1;
        if (out_valid && out_ready) begin
            out_fires++;
            if (exp_q.size() == 0) begin
                check("sb_extra", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("sb_y", out_y, e);
                check("sb_zero", out_zero, e == 8'h00);
                check("sb_ones", out_ones, e == 8'hFF);
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(cur_exp);
            accepted++;
        end
        @(posedge clk);
        #1;
    endtask

    logic [7:0] t1_exp[8]  = '{8'h3F, 8'hC0, 8'hFC, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
    logic [2:0] st_op[4]   = '{3'd4, 3'd5, 3'd0, 3'd2};
    logic [7:0] st_exp[4]  = '{8'h99, 8'h66, 8'hDB, 8'hBD};
    logic [3:0] nand_tt    = 4'b0111;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int prev;
        rst = 1'b1; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_op = 3'd0; out_ready = 1'b0;
        w1_in_valid = 1'b0; w1_in_a = 1'b0; w1_in_b = 1'b0; w1_in_op = 3'd0; w1_out_ready = 1'b0;
        cur_exp = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_y", out_y, 8'h00);
        check("rst_out_zero", out_zero, 1'b0);
        check("rst_out_ones", out_ones, 1'b0);
`ifdef GATE_ARRAY_PERF_EN
        check("rst_op_count", op_count, 16'h0000);
`endif

        // All eight ops on F0/CC with the consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_a = 8'hF0; in_b = 8'hCC; in_op = 3'(i); in_valid = 1'b1; cur_exp = t1_exp[i];
            step();
            if (i == 0) check("lat_edge1", out_valid, 1'b0);
            if (i == 1) begin
                check("lat_edge2", out_valid, 1'b1);
                check("lat_y", out_y, 8'h3F);
            end
        end
        in_valid = 1'b0;
        repeat (3) step();
        check("ops_drain", exp_q.size(), 0);

        // WIDTH=1 NAND truth table
        w1_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                w1_in_a = 1'(i >> 1); w1_in_b = 1'(i); w1_in_op = 3'd0; w1_in_valid = 1'b1;
            end else begin
                w1_in_valid = 1'b0;
            end
            step();
            if (i >= 1) begin
                check("w1_valid", w1_out_valid, 1'b1);
                check("w1_y", w1_out_y, nand_tt[i-1]);
                check("w1_ones", w1_out_ones, nand_tt[i-1]);
                check("w1_zero", w1_out_zero, !nand_tt[i-1]);
            end
        end

        // Continuous stall: two beats fill the pipe, then in_ready drops
        out_ready = 1'b0; accepted = 0;
        for (int c = 0; c < 4; c++) begin
            in_a = 8'hA5; in_b = 8'h3C; in_op = st_op[accepted]; in_valid = 1'b1;
            cur_exp = st_exp[accepted];
            step();
        end
        check("stall_acc", accepted, 2);
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_valid", out_valid, 1'b1);
        check("stall_y", out_y, 8'h99);
        step();
        check("stall_hold_y", out_y, 8'h99);
        check("stall_hold_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        #1;
        check("recover_in_ready", in_ready, 1'b1);
        out_fires = 0;
        for (int c = 0; c < 4; c++) begin
            if (accepted < 4) begin
                in_a = 8'hA5; in_b = 8'h3C; in_op = st_op[accepted]; in_valid = 1'b1;
                cur_exp = st_exp[accepted];
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        check("stall_consec", out_fires, 4);
        check("stall_drain", exp_q.size(), 0);

        // 20 random beats with out_ready toggling every cycle
        accepted = 0; out_fires = 0; prev = 0;
        put(8'($urandom), 8'($urandom), 3'($urandom_range(7, 0)));
        for (int c = 0; c < 200 && (accepted < 20 || exp_q.size() != 0); c++) begin
            out_ready = ~out_ready;
            step();
            if (accepted >= 20) in_valid = 1'b0;
            else if (accepted != prev) put(8'($urandom), 8'($urandom), 3'($urandom_range(7, 0)));
            prev = accepted;
        end
        check("tog_count", out_fires, 20);
        check("tog_drain", exp_q.size(), 0);

        // Asynchronous reset with two beats in flight
        out_ready = 1'b0; accepted = 0;
        put(8'h12, 8'h34, 3'd2);
        step();
        put(8'h56, 8'h78, 3'd1);
        step();
        check("pre_rst_acc", accepted, 2);
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_y", out_y, 8'h00);
        check("arst_in_ready", in_ready, 1'b1);
        check("arst_zero", out_zero, 1'b0);
`ifdef GATE_ARRAY_PERF_EN
        check("arst_op_count", op_count, 16'h0000);
`endif
        exp_q.delete();
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_idle", out_valid, 1'b0);
        out_ready = 1'b1;
        in_a = 8'h5A; in_b = 8'hFF; in_op = 3'd3; in_valid = 1'b1; cur_exp = 8'h00;
        step();
        in_valid = 1'b0;
        check("post_rst_lat1", out_valid, 1'b0);
        step();
        check("post_rst_lat2", out_valid, 1'b1);
        check("post_rst_y", out_y, 8'h00);
        check("post_rst_zero", out_zero, 1'b1);
        step();
        check("post_rst_drain", exp_q.size(), 0);

`ifdef GATE_ARRAY_PERF_EN
        // Counter saturation after 65540 accepted beats
        out_ready = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            in_a = 8'(i); in_b = 8'h00; in_op = 3'd7; in_valid = 1'b1; cur_exp = 8'(i);
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        check("perf_saturate", op_count, 16'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
